// File: rtl/params_pkg.sv
// Shared parameters and types for the pipeline front end.
package params_pkg;

  // Width of PCs and instruction-memory addresses.
  localparam int ADDR_WIDTH = 16;

  // First address fetched after reset.
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

  // One instruction word as returned by instruction memory.
  typedef logic [31:0] instruction_t;

  // Fetch controller states: ready to issue a read, or waiting for its data.
  typedef enum logic {
    REQ,
    WAIT
  } fetch_state_e;

  // Sequential successor of a PC; wraps naturally at the address width.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one
// instruction-memory read in flight, and hands returned instructions to
// decode through a single output register. A redirect from execute kills
// the held instruction and squashes any read still in flight.
module fetch_stage
  import params_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  instruction_t          imem_rdata_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output instruction_t          instruction_o
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  squash_q, squash_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  instruction_t          instr_q, instr_d;

  logic                  issue_req;
  logic                  load;
  logic                  slot_free;
  logic                  consume;

  // Decode takes the held instruction when it is valid and not stalled;
  // the output slot can accept new data if it is empty or being consumed.
  assign consume   = valid_q & ~mem_stall_i;
  assign slot_free = ~valid_q | ~mem_stall_i;

  // Next-state logic for the fetch controller and the decode-facing register.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    squash_d   = squash_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    issue_req  = 1'b0;
    load       = 1'b0;

    case (state_q)
      REQ: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end else if (slot_free) begin
          issue_req = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
          if (squash_q || redirect_i) begin
            squash_d = 1'b0;
            if (redirect_i) begin
              fetch_pc_d = redirect_pc_i;
            end
          end else begin
            load       = 1'b1;
            pc_d       = fetch_pc_q;
            instr_d    = imem_rdata_i;
            fetch_pc_d = next_pc(fetch_pc_q);
          end
        end else if (redirect_i) begin
          squash_d   = 1'b1;
          fetch_pc_d = redirect_pc_i;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase

    if (redirect_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      squash_q   <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      squash_q   <= squash_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  // The request is combinational from the REQ state; it is masked while
  // reset is held so no read leaves the stage during reset.
  assign imem_req_o    = issue_req & ~rst_i;
  assign imem_addr_o   = fetch_pc_q;
  assign valid_o       = valid_q;
  assign pc_o          = pc_q;
  assign instruction_o = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable instruction memory, a
// directed sequence for the timing corner cases, a randomized phase, and a
// scoreboard monitor that checks every request address and every
// instruction decode consumes against an in-order fetch model.
module tb_fetch_stage;
  import params_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] TOP_PC = ~ADDR_WIDTH'(3);

  typedef struct {
    logic [ADDR_WIDTH-1:0] pc;
    instruction_t          instr;
  } fetch_item_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  mem_stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  instruction_t          imem_rdata;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] pc;
  instruction_t          instr;

  int checks = 0;
  int errors = 0;
  int lat_fixed = 1;
  int consumed = 0;
  int progress_start;

  fetch_item_t           sb[$];
  fetch_item_t           sb_item;
  logic [ADDR_WIDTH-1:0] next_req_pc;
  logic                  hold_pending;
  logic                  inval_pending;
  logic [ADDR_WIDTH-1:0] held_pc;
  instruction_t          held_instr;

  logic                  mem_pending;
  int                    mem_cnt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ADDR_WIDTH-1:0] rand_target;

  fetch_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_stall_i   (mem_stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .valid_o       (valid),
    .pc_o          (pc),
    .instruction_o (instr)
  );

  always #5 clk = ~clk;

  // Instruction content the memory holds at each address.
  function automatic instruction_t instr_at(input logic [ADDR_WIDTH-1:0] addr);
    return 32'h0000_0013 + 32'(addr);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic redir, input logic [ADDR_WIDTH-1:0] target);
    mem_stall   = stall;
    redirect    = redir;
    redirect_pc = target;
  endtask

  // Instruction memory: latches a request at mid-cycle and answers after
  // lat_fixed cycles (random 1..3 when lat_fixed is 0).
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    mem_pending = 1'b0;
    mem_cnt     = 0;
    mem_addr    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_pending = 1'b0;
      end else begin
        if (imem_rvalid) mem_pending = 1'b0;
        if (imem_req) begin
          mem_pending = 1'b1;
          mem_addr    = imem_addr;
          mem_cnt     = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
        end
      end
      @(posedge clk);
      #1;
      if (mem_pending) begin
        mem_cnt--;
        imem_rvalid = (mem_cnt == 0);
        imem_rdata  = (mem_cnt == 0) ? instr_at(mem_addr) : 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard monitor: requests follow the fetch path (sequential, restarted
  // by each redirect); every request pushes its expected instruction, a
  // redirect flushes all wrong-path work, and each consume pops and compares.
  initial begin
    next_req_pc   = RESET_PC;
    hold_pending  = 1'b0;
    inval_pending = 1'b0;
    held_pc       = '0;
    held_instr    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        next_req_pc   = RESET_PC;
        hold_pending  = 1'b0;
        inval_pending = 1'b0;
      end else begin
        if (inval_pending) begin
          checkOutput("redirect_clears_valid", 32'(valid), 32'd0);
        end
        if (hold_pending) begin
          checkOutput("stall_hold_valid", 32'(valid), 32'd1);
          checkOutput("stall_hold_pc", 32'(pc), 32'(held_pc));
          checkOutput("stall_hold_instr", instr, held_instr);
        end
        inval_pending = 1'b0;
        hold_pending  = 1'b0;

        if (redirect) begin
          sb.delete();
          next_req_pc   = redirect_pc;
          inval_pending = 1'b1;
        end else if (valid && !mem_stall) begin
          consumed++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL consume_order: got pc 0x%0h, expected no valid output at %0t", pc, $time);
          end else begin
            sb_item = sb.pop_front();
            checkOutput("consume_pc", 32'(pc), 32'(sb_item.pc));
            checkOutput("consume_instr", instr, sb_item.instr);
          end
        end else if (valid && mem_stall) begin
          hold_pending = 1'b1;
          held_pc      = pc;
          held_instr   = instr;
        end

        if (imem_req) begin
          checkOutput("req_slot_free", 32'(valid && mem_stall), 32'd0);
          checkOutput("req_no_redirect", 32'(redirect), 32'd0);
          checkOutput("req_addr", 32'(imem_addr), 32'(next_req_pc));
          sb_item.pc    = next_req_pc;
          sb_item.instr = instr_at(next_req_pc);
          sb.push_back(sb_item);
          next_req_pc = next_req_pc + ADDR_WIDTH'(4);
        end
      end
    end
  end

  // Directed corner cases, randomized traffic, wrap and asynchronous reset.
  initial begin
    applyStimulus(1'b0, 1'b0, '0);
    rst       = 1'b1;
    lat_fixed = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c <= 19; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      case (c)
        4:  applyStimulus(1'b1, 1'b0, '0);
        7:  begin applyStimulus(1'b0, 1'b0, '0); lat_fixed = 3; end
        8:  applyStimulus(1'b0, 1'b1, ADDR_WIDTH'('h100));
        9:  applyStimulus(1'b0, 1'b0, '0);
        15: applyStimulus(1'b1, 1'b1, ADDR_WIDTH'('h40));
        16: begin applyStimulus(1'b0, 1'b0, '0); lat_fixed = 1; end
        default: ;
      endcase
      @(negedge clk);
      if (c == 0) begin
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("first_req_addr", 32'(imem_addr), 32'(RESET_PC));
      end
      if (c <= 3) begin
        checkOutput("basic_req_cadence", 32'(imem_req), 32'(c % 2 == 0));
        checkOutput("basic_valid_cadence", 32'(valid), 32'(c == 2));
      end
      if (c >= 4 && c <= 6) begin
        checkOutput("stall_no_req", 32'(imem_req), 32'd0);
        checkOutput("stall_valid", 32'(valid), 32'd1);
        checkOutput("stall_pc", 32'(pc), 32'h4);
      end
      if (c == 7) begin
        checkOutput("release_req", 32'(imem_req), 32'd1);
        checkOutput("release_addr", 32'(imem_addr), 32'h8);
      end
      if (c >= 8 && c <= 14) begin
        checkOutput("squashed_hidden", 32'(valid), 32'd0);
      end
      if (c == 11) begin
        checkOutput("redirect_wait_req", 32'(imem_req), 32'd1);
        checkOutput("redirect_wait_addr", 32'(imem_addr), 32'h100);
      end
      if (c == 15) begin
        checkOutput("redirect_target_valid", 32'(valid), 32'd1);
        checkOutput("redirect_target_pc", 32'(pc), 32'h100);
      end
      if (c == 16) begin
        checkOutput("stall_redirect_valid", 32'(valid), 32'd0);
        checkOutput("stall_redirect_req", 32'(imem_req), 32'd1);
        checkOutput("stall_redirect_addr", 32'(imem_addr), 32'h40);
      end
    end

    lat_fixed      = 0;
    progress_start = consumed;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      rand_target = ($urandom_range(0, 3) == 0) ? TOP_PC : (ADDR_WIDTH'($urandom) & ~ADDR_WIDTH'(3));
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rand_target);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (6) @(posedge clk);
    checkOutput("random_progress", 32'(consumed - progress_start > 20), 32'd1);

    #1;
    lat_fixed = 1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, TOP_PC);
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == 1) applyStimulus(1'b0, 1'b0, '0);
      if (c == 3) lat_fixed = 3;
      @(negedge clk);
      if (c == 0) checkOutput("wrap_redirect_no_req", 32'(imem_req), 32'd0);
      if (c == 1) checkOutput("wrap_first_addr", 32'(imem_addr), 32'(TOP_PC));
      if (c == 3) begin
        checkOutput("wrap_second_req", 32'(imem_req), 32'd1);
        checkOutput("wrap_second_addr", 32'(imem_addr), 32'd0);
      end
    end

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_req", 32'(imem_req), 32'd0);
    checkOutput("async_reset_valid", 32'(valid), 32'd0);
    checkOutput("async_reset_pc", 32'(pc), 32'd0);
    checkOutput("async_reset_instr", instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    lat_fixed = 1;
    rst       = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_req", 32'(imem_req), 32'd1);
    checkOutput("post_reset_addr", 32'(imem_addr), 32'(RESET_PC));
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
